// File: rtl/btc_host_driver.sv
// Host side of the mining tile byte port: serves header/nonce bytes,
// captures returned hashes and sweeps the nonce until a hit or range end.
module btc_host_driver #(
    parameter int HDR_BYTES = 80
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hdr_we,
    input  logic [6:0]   hdr_addr,
    input  logic [7:0]   hdr_wdata,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         go,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  found_nonce,
    output logic [255:0] last_hash,
    output logic         hash_valid,
    output logic         addr_err,
    output logic         dut_start,
    output logic         dut_rdy,
    output logic [7:0]   dut_data,
    input  logic         dut_rq,
    input  logic         dut_done,
    input  logic [7:0]   dut_uo
);
    localparam int NB = HDR_BYTES - 4;
    localparam logic [6:0] NONCE_LO = 7'(NB);
    localparam logic [6:0] HDR_END = 7'(HDR_BYTES);

    typedef enum logic [2:0] {IDLE, KICK, SERVE, DRAIN, CHECK} state_t;
    state_t state;

    logic [7:0]   hdr_ram [0:NB-1];
    logic [7:0]   cap [0:31];
    logic [5:0]   cap_idx;
    logic [31:0]  nonce;
    logic [31:0]  nonce_last;
    logic [6:0]   off;
    logic [7:0]   rd_byte;
    logic         rd_bad;
    logic         ack;
    logic [255:0] cap_msb0;
    logic [255:0] cap_val;

    assign off = dut_uo[6:0];
    assign ack = dut_rq && !dut_rdy;

    always_comb begin
        rd_byte = 8'h00;
        rd_bad = 1'b0;
        if (off < NONCE_LO) begin
            rd_byte = hdr_ram[off];
        end else if (off < HDR_END) begin
            rd_byte = nonce[{off[1:0], 3'b000} +: 8];
        end else begin
            rd_bad = 1'b1;
        end
    end

    // last_hash keeps byte 0 on top; the compare value has byte 31 on top
    always_comb begin
        cap_msb0 = '0;
        cap_val = '0;
        for (int i = 0; i < 32; i++) begin
            cap_msb0[255-8*i -: 8] = cap[i];
            cap_val[8*i +: 8] = cap[i];
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_we && !busy && hdr_addr < NONCE_LO)
            hdr_ram[hdr_addr] <= hdr_wdata;
    end

    always_ff @(posedge clk) begin
        if (ack && dut_done && cap_idx < 6'd32)
            cap[cap_idx[4:0]] <= dut_uo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= '0;
            last_hash   <= '0;
            hash_valid  <= 1'b0;
            addr_err    <= 1'b0;
            dut_start   <= 1'b0;
            dut_rdy     <= 1'b0;
            dut_data    <= 8'h00;
            cap_idx     <= '0;
            nonce       <= '0;
            nonce_last  <= '0;
        end else begin
            dut_start  <= 1'b0;
            hash_valid <= 1'b0;
            if (dut_rdy) begin
                dut_rdy <= 1'b0;
            end else if (dut_rq) begin
                dut_rdy <= 1'b1;
                if (dut_done) begin
                    if (cap_idx == 6'd32)
                        addr_err <= 1'b1;
                    else
                        cap_idx <= cap_idx + 6'd1;
                end else begin
                    dut_data <= rd_byte;
                    if (rd_bad)
                        addr_err <= 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (go) begin
                        nonce      <= nonce_start;
                        nonce_last <= nonce_end;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        addr_err   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= KICK;
                    end
                end
                KICK: begin
                    dut_start <= 1'b1;
                    cap_idx   <= '0;
                    state     <= SERVE;
                end
                SERVE: begin
                    if (cap_idx == 6'd32)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!dut_done)
                        state <= CHECK;
                end
                CHECK: begin
                    last_hash  <= cap_msb0;
                    hash_valid <= 1'b1;
                    if (cap_val <= target) begin
                        found       <= 1'b1;
                        found_nonce <= nonce;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (nonce == nonce_last) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        nonce <= nonce + 32'd1;
                        state <= KICK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/btc_host_driver.md
# btc_host_driver

Host-side counterpart of the mining tile's byte-serial port. It holds an 80-byte block header and answers the tile's byte requests (rq/rdy), injecting a nonce into header bytes 76..79. It captures the 32 hash bytes the tile writes back and compares them against a 256-bit target. It then sweeps the nonce until a hit or the end of the range. It sits in the companion FPGA / test harness, wired directly to the tile's ui_in, uo_out and uio pins on the same clock.

## Interface
Parameters:
- HDR_BYTES, 80, header length in bytes; bytes HDR_BYTES-4..HDR_BYTES-1 are the nonce.

Ports:
- clk  in  1  clock, shared with the tile.
- rst_n  in  1  asynchronous, active-low reset.
- hdr_we  in  1  header byte write strobe; honoured only when busy=0.
- hdr_addr  in  7  header byte index; writes with index ≥ 76 ignored.
- hdr_wdata  in  8  header byte value.
- target  in  256  hit threshold; held stable while busy.
- nonce_start  in  32  first nonce; sampled on go.
- nonce_end  in  32  last nonce (inclusive); sampled on go.
- go  in  1  start sweep; ignored when busy=1.
- busy  out  1  sweep in progress.
- found  out  1  sticky until next go: hit found.
- exhausted  out  1  sticky until next go: range finished, no hit.
- found_nonce  out  32  nonce of the hit.
- last_hash  out  256  last captured hash, byte 0 in [255:248].
- hash_valid  out  1  one-cycle pulse when last_hash updates.
- addr_err  out  1  sticky until next go: rq with byte offset ≥ 80, or a 33rd hash-byte rq.
- dut_start  out  1  to tile uio_in[0].
- dut_rdy  out  1  to tile uio_in[1].
- dut_data  out  8  to tile ui_in.
- dut_rq  in  1  from tile uio_out[2].
- dut_done  in  1  from tile uio_out[3].
- dut_uo  in  8  from tile uo_out.

## Operation
- Reset: every output 0, state IDLE, header RAM contents undefined.
- Request decode when dut_done=0: byte offset = dut_uo[6:2]*4 + dut_uo[1:0]. Offsets 0..75 read header RAM. Offsets 76..79 return nonce byte (offset-76), little-endian (76 = nonce[7:0]). Offsets ≥ 80 return 0x00 and set addr_err.
- Request with dut_done=1: dut_uo is hash byte k. Store it at capture index k (0..31). At k=32 the byte is not stored and addr_err is set.
- Ack rule, all states: on an edge where dut_rq=1 and dut_rdy=0, the next cycle has dut_rdy=1 and dut_data valid. On the edge where dut_rdy=1, dut_rdy returns to 0. This gives exactly one rdy cycle per request.
- States:
  - IDLE: go → latch nonce range, clear found/exhausted/addr_err, busy=1, go to KICK.
  - KICK: dut_start=1 for one cycle, capture index ← 0, go to SERVE.
  - SERVE: serve requests. After the 32nd capture, go to DRAIN.
  - DRAIN: wait for dut_done=0, then go to CHECK.
  - CHECK (one cycle): last_hash ← captured bytes and hash_valid pulses. Form the comparison value H = {byte31..byte0} (byte 31 most significant). If H ≤ target: found=1, found_nonce=nonce, go to IDLE. Else if nonce == nonce_end: exhausted=1, go to IDLE. Else nonce ← nonce+1 (mod 2^32), go to KICK. busy=0 on IDLE entry.
- nonce_start > nonce_end: nonce wraps through 0xFFFFFFFF→0 until it equals nonce_end.
- Reset mid-sweep returns to IDLE at once with all outputs 0; no partial result is reported.

## Timing
- go sampled at edge e → busy=1 after e, dut_start high the cycle after that.
- rq first high at edge k → rdy/data at k+1, rdy low at k+2. With the tile's re-request, the minimum is 3 cycles per byte.
- dut_data holds its value until the next ack. It is driven 0x00 when no ack has occurred since reset.
- CHECK → KICK costs 1 cycle; hash_valid coincides with the first cycle after CHECK.
- hdr_we with busy=1 is dropped silently.

## Test plan
- Reset: assert rst_n=0 mid-SERVE → all outputs 0, busy=0; after release, no dut_rdy pulse without a new dut_rq rising.
- Header service: header byte i = i; model drives rq with dut_uo={0,5'd3,2'd2} → dut_data=0x0E, dut_rdy high exactly one cycle.
- Nonce injection: nonce_start=0x11223344; requests for word 19, bytes 0..3 → 0x44, 0x33, 0x22, 0x11.
- Hit: target all-ones; tile model returns 32 bytes of 0xA5 → hash_valid pulse, last_hash = 32×0xA5, found=1, found_nonce=nonce_start, busy=0.
- Exhaustion: target=0, nonce_start=5, nonce_end=7, non-zero hashes → exactly 3 dut_start pulses, exhausted=1, found=0.
- Error: rq with dut_uo={0,5'd20,2'd0} → dut_data=0x00, addr_err=1; a 33rd hash-byte rq is acked and addr_err=1.
